// File: rtl/frc_sched_pkg.sv
// Shared types for the fraction-check scheduler: FSM state codes and default operand width.
package frc_sched_pkg;

    localparam int FP_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/frc_check_sched_if.sv
// Requester-side bundle of the scheduler: request handshake in, one-hot response out.
interface frc_check_sched_if #(
    parameter int N_REQ = 4,
    parameter int FP_W  = 32
);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*FP_W-1:0] req_num;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      rsp_valid;
    logic                  rsp_res;
    logic                  rsp_err;

    modport master (
        output req_valid, req_num,
        input  req_ready, rsp_valid, rsp_res, rsp_err
    );

    modport slave (
        input  req_valid, req_num,
        output req_ready, rsp_valid, rsp_res, rsp_err
    );

endinterface

// File: rtl/frc_check_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from ptr, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/frc_check_sched.sv
// Shares one fraction-check unit among N_REQ requesters (round-robin, one operation at a time).
// Optional WAIT timeout enabled by defining FRC_SCHED_TIMEOUT_EN.
module frc_check_sched
    import frc_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FP_W        = FP_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    frc_check_sched_if.slave  bus,
    output logic              busy,
    output logic              chk_start,
    output logic [FP_W-1:0]   chk_num,
    input  logic              chk_done,
    input  logic              chk_res
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             transfer;
    logic [N_REQ-1:0] rsp_valid_q;
    logic             rsp_res_q;

`ifdef FRC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .index (grant_idx)
    );

    assign bus.req_ready = (state == S_IDLE) ? grant : '0;
    assign transfer      = |(bus.req_valid & bus.req_ready);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;

    // Pointer advances only on an accepted transfer, so a dropped request does not skip anyone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            chk_start   <= 1'b0;
            chk_num     <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= 1'b0;
`ifdef FRC_SCHED_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        chk_num   <= bus.req_num[int'(grant_idx)*FP_W +: FP_W];
                        idx       <= grant_idx;
                        ptr       <= (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
                        chk_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    chk_start <= 1'b0;
`ifdef FRC_SCHED_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still wins and reports a clean result.
                    if (chk_done) begin
                        rsp_valid_q <= N_REQ'(1) << idx;
                        rsp_res_q   <= chk_res;
`ifdef FRC_SCHED_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= S_RESP;
                    end
`ifdef FRC_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        rsp_valid_q <= N_REQ'(1) << idx;
                        rsp_res_q   <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    rsp_res_q   <= 1'b0;
`ifdef FRC_SCHED_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frc_check_sched.sv
// Directed bench for frc_check_sched with a 3-cycle fraction-checker model and a response scoreboard.
module tb_frc_check_sched;

    localparam int N_REQ = 4;
    localparam int FP_W  = 32;

    typedef struct {
        int   idx;
        logic res;
        logic err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            busy;
    logic            chk_start;
    logic [FP_W-1:0] chk_num;
    logic            chk_done;
    logic            chk_res;

    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    logic            m_res  = 1'b0;
    logic [1:0]      m_left = 2'd0;
    logic            m_mute = 1'b0;
    logic            spur_done = 1'b0;
    logic            spur_res  = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    frc_check_sched_if #(.N_REQ(N_REQ), .FP_W(FP_W)) bus ();

    frc_check_sched #(.N_REQ(N_REQ), .FP_W(FP_W), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .chk_start (chk_start),
        .chk_num   (chk_num),
        .chk_done  (chk_done),
        .chk_res   (chk_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference meaning of the checker: does the float have a non-zero fractional part.
    function automatic logic has_frac(input logic [31:0] f);
        int          e;
        logic [22:0] mask;
        e = int'(f[30:23]) - 127;
        if (f[30:23] == 8'hFF || f[30:0] == 31'd0) return 1'b0;
        if (e < 0) return 1'b1;
        if (e >= 23) return 1'b0;
        mask = (23'(1) << (23 - e)) - 23'(1);
        return (f[22:0] & mask) != 23'd0;
    endfunction

    // Checker model: done is high exactly three cycles after the cycle start was high.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (chk_start && !m_mute) begin
            m_busy <= 1'b1;
            m_left <= 2'd2;
            m_res  <= has_frac(chk_num);
        end else if (m_busy) begin
            if (m_left == 2'd1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_left <= m_left - 2'd1;
            end
        end
    end

    assign chk_done = m_done | spur_done;
    assign chk_res  = m_res  | spur_res;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_onehot", 64'(bus.rsp_valid), 64'(1) << e.idx);
                checkOutput("rsp_res", 64'(bus.rsp_res), 64'(e.res));
                checkOutput("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            end
        end
    end

    task automatic resetDut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_start", 64'(chk_start), 64'd0);
        checkOutput("rst_num", 64'(chk_num), 64'd0);
        checkOutput("rst_rsp", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One request from a single requester; checks accept, launch and response latency.
    task automatic applyStimulus(input int idx, input logic [31:0] num, input logic res,
                                 input logic err, input int exp_lat);
        int lat;
        bus.req_num[idx*FP_W +: FP_W] = num;
        bus.req_valid[idx] = 1'b1;
        sb.push_back('{idx, res, err});
        @(negedge clk);
        checkOutput("ready", 64'(bus.req_ready), 64'(1) << idx);
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
        @(negedge clk);
        checkOutput("chk_start", 64'(chk_start), 64'd1);
        checkOutput("chk_num", 64'(chk_num), 64'(num));
        checkOutput("ready_busy", 64'(bus.req_ready), 64'd0);
        lat = 1;
        while (bus.rsp_valid === '0 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic waitGrant(output int gidx, output int gcyc);
        int n;
        gidx = -1;
        gcyc = 0;
        n    = 0;
        while (gidx < 0 && n < 60) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    gidx = i;
                    gcyc = cyc;
                end
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drainScoreboard(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          g, c, prev;
        int          seq3 [5] = '{0, 1, 2, 3, 0};
        int          seq4 [4] = '{0, 2, 0, 2};
        logic [31:0] nums [4] = '{32'h3FC00000, 32'h40400000, 32'h40200000, 32'h40800000};
        logic        ress [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_num   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rsp", 64'(bus.rsp_valid), 64'd0);
        checkOutput("reset_res", 64'(bus.rsp_res), 64'd0);
        checkOutput("reset_err", 64'(bus.rsp_err), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single requests");
        applyStimulus(0, 32'h3FC00000, 1'b1, 1'b0, 5);
        applyStimulus(1, 32'h40400000, 1'b0, 1'b0, 5);
        applyStimulus(1, 32'h40200000, 1'b1, 1'b0, 5);

        $display("[TB] all four held");
        resetDut();
        for (int i = 0; i < N_REQ; i++) bus.req_num[i*FP_W +: FP_W] = nums[i];
        for (int k = 0; k < 5; k++) sb.push_back('{seq3[k], ress[seq3[k]], 1'b0});
        bus.req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            waitGrant(g, c);
            checkOutput("t3_grant", 64'(g), 64'(seq3[k]));
            if (k > 0) checkOutput("t3_gap", 64'(c - prev), 64'd6);
            prev = c;
        end
        bus.req_valid = '0;
        drainScoreboard("t3_drain");

        $display("[TB] requesters 0 and 2 held");
        resetDut();
        for (int k = 0; k < 4; k++) sb.push_back('{seq4[k], ress[seq4[k]], 1'b0});
        bus.req_valid = 4'b0101;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            waitGrant(g, c);
            checkOutput("t4_grant", 64'(g), 64'(seq4[k]));
            if (k > 0) checkOutput("t4_gap", 64'(c - prev), 64'd6);
            prev = c;
        end
        bus.req_valid = '0;
        drainScoreboard("t4_drain");

        $display("[TB] reset during WAIT");
        bus.req_num[1*FP_W +: FP_W] = 32'h3FC00000;
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        checkOutput("t5_ready", 64'(bus.req_ready), 64'b0010);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        resetDut();
        repeat (3) @(negedge clk);
        checkOutput("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        applyStimulus(3, 32'h40200000, 1'b1, 1'b0, 5);

        $display("[TB] spurious done in IDLE");
        spur_done = 1'b1;
        spur_res  = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        spur_res  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
        checkOutput("t6_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        bus.req_num[0*FP_W +: FP_W] = 32'h3FC00000;
        bus.req_num[3*FP_W +: FP_W] = 32'h40800000;
        bus.req_valid = 4'b1001;
        sb.push_back('{0, 1'b1, 1'b0});
        @(negedge clk);
        checkOutput("t6_ptr_kept", 64'(bus.req_ready), 64'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drainScoreboard("t6_drain");

`ifdef FRC_SCHED_TIMEOUT_EN
        $display("[TB] checker never answers");
        m_mute = 1'b1;
        applyStimulus(2, 32'h3FC00000, 1'b0, 1'b1, 18);
        m_mute = 1'b0;
        drainScoreboard("tmo_drain");
`endif

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
